// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Brief    : Shared widths, column-major byte indexing, ShiftRows source map
//            and FSM encoding for the AES SubBytes/ShiftRows stage.
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

   localparam int STATE_W = 128;
   localparam int BYTE_W  = 8;
   localparam int NROWS   = 4;
   localparam int NCOLS   = 4;
   localparam int NBYTES  = NROWS * NCOLS;

   typedef logic [STATE_W-1:0] aes_state_t;
   typedef logic [BYTE_W-1:0]  aes_byte_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SUB  = 2'd1,
      ST_DONE = 2'd2
   } fsm_t;

   // Column-major placement: byte 4c+r holds s[r,c].
   function automatic int byte_idx(input int r, input int c);
      return NROWS * c + r;
   endfunction

   // ShiftRows: output s'[r,c] is taken from s[r,(c+r) mod 4].
   function automatic int shift_src(input int r, input int c);
      return byte_idx(r, (c + r) % NCOLS);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sbox.sv
`default_nettype none
// ============================================================================
// Module   : sbox
// Brief    : Combinational AES forward S-box byte lookup.
// Revision : 1.0 - initial release
// ============================================================================
module sbox (
   input  logic [7:0] i_addr,
   output logic [7:0] o_data
);

   localparam logic [7:0] C_TABLE [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign o_data = C_TABLE[i_addr];

endmodule
`default_nettype wire

// File: rtl/aes_subshift_iter.sv
`default_nettype none
// ============================================================================
// Module   : aes_subshift_iter
// Brief    : Iterative AES SubBytes + ShiftRows. LANES bytes are substituted
//            per cycle in place, then the ShiftRows permutation is captured
//            into out_state and offered over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module aes_subshift_iter
   import aes_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [STATE_W-1:0] in_state,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [STATE_W-1:0] out_state,
   output logic               busy
);

   localparam int NCYC  = NBYTES / LANES;
   localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
   localparam int IDX_W = $clog2(NBYTES);

   // Byte arrays: element b is state byte b (byte 0 = in_state[127:120]).
   fsm_t                         r_state;
   fsm_t                         w_state_nxt;
   logic [CNT_W-1:0]             r_cnt;
   logic [NBYTES-1:0][BYTE_W-1:0] r_work;
   logic [NBYTES-1:0][BYTE_W-1:0] w_in_bytes;
   logic [NBYTES-1:0][BYTE_W-1:0] w_work_sub;
   logic [LANES-1:0][BYTE_W-1:0]  w_sb_out;
   logic [LANES-1:0][IDX_W-1:0]   w_idx;
   aes_state_t                   w_shift_flat;
   aes_state_t                   r_out;
   logic                         w_last;

   assign w_last    = (r_cnt == CNT_W'(NCYC - 1));
   assign out_state = r_out;

   // Lane l substitutes byte cnt*LANES + l of the working register.
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign w_idx[l] = IDX_W'(r_cnt) * IDX_W'(LANES) + IDX_W'(l);
      sbox u_sbox (
         .i_addr (r_work[w_idx[l]]),
         .o_data (w_sb_out[l])
      );
   end

   // Per-byte wiring: unpack input, merge this cycle's substitutions, and
   // route the fully substituted bytes through the ShiftRows permutation.
   for (genvar b = 0; b < NBYTES; b++) begin : g_byte
      assign w_in_bytes[b] = in_state[STATE_W-1-BYTE_W*b -: BYTE_W];
      assign w_work_sub[b] = (r_cnt == CNT_W'(b / LANES)) ? w_sb_out[b % LANES] : r_work[b];
      assign w_shift_flat[STATE_W-1-BYTE_W*b -: BYTE_W] = w_work_sub[shift_src(b % NROWS, b / NROWS)];
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = ST_SUB;
         end
         ST_SUB: begin
            busy = 1'b1;
            if (w_last) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Working register, lane counter and output capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_work <= '0;
         r_cnt  <= '0;
         r_out  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_work <= w_in_bytes;
                  r_cnt  <= '0;
               end
            end
            ST_SUB: begin
               r_work <= w_work_sub;
               r_cnt  <= r_cnt + CNT_W'(1);
               if (w_last) r_out <= w_shift_flat;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_aes_subshift_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_subshift_iter
// Brief    : Self-checking bench for aes_subshift_iter (LANES 4, 1 and 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_subshift_iter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         iv_x;
   logic         out_ready;
   logic [127:0] in_state;
   logic         in_ready, out_valid, busy;
   logic [127:0] out_state;
   logic         rdy1, val1, busy1, rdy16, val16, busy16;
   logic [127:0] os1, os16;

   int total = 0;
   int bad   = 0;
   logic [127:0] exp_q [$];
   logic [127:0] vin  [3];
   logic [127:0] vout [3];

   always #5 clk = ~clk;

   aes_subshift_iter #(.LANES(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready),
      .out_state(out_state), .busy(busy)
   );

   aes_subshift_iter #(.LANES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_x), .in_ready(rdy1),
      .in_state(in_state), .out_valid(val1), .out_ready(out_ready),
      .out_state(os1), .busy(busy1)
   );

   aes_subshift_iter #(.LANES(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_x), .in_ready(rdy16),
      .in_state(in_state), .out_valid(val16), .out_ready(out_ready),
      .out_state(os16), .busy(busy16)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; iv_x = 1'b0; out_ready = 1'b1; in_state = '0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (out_state !== 128'h0) begin bad++; $display("FAIL reset_out_state got=%h want=0", out_state); end
      #2 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single(input int k, input string nm);
      int lat;
      logic [127:0] e;
      out_ready = 1'b1;
      in_state  = vin[k];
      in_valid  = 1'b1;
      exp_q.push_back(vout[k]);
      tick();
      in_valid = 1'b0;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy got=%b want=1", nm, busy); end
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      total++; if (lat != 4) begin bad++; $display("FAIL %s_latency got=%0d want=4", nm, lat); end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
      total++; if (out_state !== e) begin bad++; $display("FAIL %s_out_state got=%h want=%h", nm, out_state, e); end
      tick();
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++; $display("FAIL %s_return_idle got=%b%b want=10", nm, in_ready, out_valid);
      end
   endtask

   task automatic test_backpressure;
      int lat;
      logic [127:0] e;
      out_ready = 1'b0;
      in_state  = vin[2];
      in_valid  = 1'b1;
      exp_q.push_back(vout[2]);
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
      total++; if (out_state !== e) begin bad++; $display("FAIL bp_out_state got=%h want=%h", out_state, e); end
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         tick();
         total++; if (out_valid !== 1'b1 || out_state !== e || in_ready !== 1'b0) begin
            bad++; $display("FAIL bp_hold cyc=%0d got v=%b r=%b s=%h want v=1 r=0 s=%h", i, out_valid, in_ready, out_state, e);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL bp_release got v=%b r=%b want v=0 r=1", out_valid, in_ready);
      end
      total++; if (out_state !== e) begin bad++; $display("FAIL bp_retain got=%h want=%h", out_state, e); end
   endtask

   task automatic test_back_to_back;
      int acc = 0;
      int got = 0;
      logic [127:0] e;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         in_state = vin[cyc % 3];
         if (in_ready === 1'b1) begin
            exp_q.push_back(vout[cyc % 3]);
            acc++;
         end
         if (out_valid === 1'b1) begin
            got++;
            total++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL b2b_unexpected got=%h want=none", out_state);
            end else begin
               e = exp_q.pop_front();
               if (out_state !== e) begin bad++; $display("FAIL b2b_out_state got=%h want=%h", out_state, e); end
            end
         end
         tick();
      end
      in_valid = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (out_valid === 1'b1) begin
            got++;
            total++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL b2b_unexpected got=%h want=none", out_state);
            end else begin
               e = exp_q.pop_front();
               if (out_state !== e) begin bad++; $display("FAIL b2b_out_state got=%h want=%h", out_state, e); end
            end
         end
         tick();
      end
      total++; if (acc != 7) begin bad++; $display("FAIL b2b_accepts got=%0d want=7", acc); end
      total++; if (got != acc) begin bad++; $display("FAIL b2b_outputs got=%0d want=%0d", got, acc); end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_leftover got=%0d want=0", exp_q.size()); end
   endtask

   task automatic test_async_reset;
      in_state = vin[0];
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL arst_pre_busy got=%b want=1", busy); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++; $display("FAIL arst_outputs got b=%b r=%b v=%b want b=0 r=1 v=0", busy, in_ready, out_valid);
      end
      total++; if (out_state !== 128'h0) begin bad++; $display("FAIL arst_out_state got=%h want=0", out_state); end
      for (int i = 0; i < 6; i++) begin
         tick();
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_no_valid got=%b want=0", out_valid); end
      end
      #1 rst_n = 1'b1;
      tick();
      test_single(1, "post_reset");
   endtask

   task automatic test_lanes;
      int lat1 = 0, lat4 = 0, lat16 = 0;
      logic [127:0] c1, c4, c16;
      c1 = '0; c4 = '0; c16 = '0;
      out_ready = 1'b1;
      in_state  = vin[0];
      in_valid  = 1'b1;
      iv_x      = 1'b1;
      tick();
      in_valid = 1'b0;
      iv_x     = 1'b0;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         if (val1 === 1'b1 && lat1 == 0) begin lat1 = cyc - 1; c1 = os1; end
         if (out_valid === 1'b1 && lat4 == 0) begin lat4 = cyc - 1; c4 = out_state; end
         if (val16 === 1'b1 && lat16 == 0) begin lat16 = cyc - 1; c16 = os16; end
         tick();
      end
      total++; if (lat1 != 16) begin bad++; $display("FAIL lanes1_latency got=%0d want=16", lat1); end
      total++; if (lat4 != 4) begin bad++; $display("FAIL lanes4_latency got=%0d want=4", lat4); end
      total++; if (lat16 != 1) begin bad++; $display("FAIL lanes16_latency got=%0d want=1", lat16); end
      total++; if (c1 !== vout[0]) begin bad++; $display("FAIL lanes1_out_state got=%h want=%h", c1, vout[0]); end
      total++; if (c4 !== vout[0]) begin bad++; $display("FAIL lanes4_out_state got=%h want=%h", c4, vout[0]); end
      total++; if (c16 !== vout[0]) begin bad++; $display("FAIL lanes16_out_state got=%h want=%h", c16, vout[0]); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vin[0]  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
      vout[0] = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
      vin[1]  = 128'h0;
      vout[1] = 128'h63636363636363636363636363636363;
      vin[2]  = 128'ha49c7ff2689f352b6b5bea43026a5049;
      vout[2] = 128'h49db873b453953897f02d2f177de961a;

      test_reset();
      test_single(0, "fips_r1");
      test_single(1, "zero");
      test_single(2, "fips_r2");
      test_backpressure();
      test_back_to_back();
      test_async_reset();
      test_lanes();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
